// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op-code values, flag bit
// positions inside the 4-bit flags word, and the FSM state encoding.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_NOT = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    localparam int FLG_Z = 0;
    localparam int FLG_N = 1;
    localparam int FLG_V = 2;
    localparam int FLG_C = 3;

    // ST_MUL is only ever entered when the iterative multiplier is built in.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier, one bit of b per cycle.
// The start cycle consumes bit 0 and the following WIDTH-1 cycles consume
// the remaining bits, so done rises exactly WIDTH edges after start was
// sampled. done and product then hold until the next start or reset, which
// lets the owner wait for its output register to free up.
module alu_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [SHW-1:0]     cnt;
    logic               running;

    // Load on start (doing the bit-0 step), then accumulate one partial product per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else if (start) begin
            acc     <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
            mcand   <= {{(WIDTH-1){1'b0}}, a, 1'b0};
            mplier  <= b >> 1;
            cnt     <= SHW'(1);
            running <= 1'b1;
            done    <= 1'b0;
        end else if (running) begin
            acc    <= acc + (mplier[0] ? mcand : '0);
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + SHW'(1);
            if (cnt == LAST) begin
                running <= 1'b0;
                done    <= 1'b1;
            end
        end
    end

    assign product = acc;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready on both sides.
// Optional feature macro ALU_MUL_EN: when defined, op 110 runs the
// iterative multiplier (WIDTH-cycle latency, busy high meanwhile); when
// undefined, op 110 returns zero with latency 1 and busy is tied low.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; the sender holds its payload until then, and the payload is
// sampled only on that edge. Inputs: in_valid/in_ready; outputs:
// out_valid/out_ready, where result/flags are stable while out_valid is held.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);

    state_t           state;
    logic             out_free;
    logic             accept;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic [3:0]       alu_flags;

    assign out_free = !out_valid || out_ready;
    assign in_ready = (state == ST_IDLE) && out_free;
    assign accept   = in_valid && in_ready;

    // Single-cycle op datapath and its status flags.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OP_ADD: begin
                {alu_c, alu_res} = {1'b0, a} + {1'b0, b};
                alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = a - b;
                alu_c   = (a < b);
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  alu_res = a & b;
            OP_NOT:  alu_res = ~a;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_SHR:  alu_res = a >> b[SHW-1:0];
            default: alu_res = '0;
        endcase
        alu_flags        = '0;
        alu_flags[FLG_C] = alu_c;
        alu_flags[FLG_V] = alu_v;
        alu_flags[FLG_N] = alu_res[WIDTH-1];
        alu_flags[FLG_Z] = (alu_res == '0);
    end

`ifdef ALU_MUL_EN
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;
    logic [3:0]         mul_flags;

    assign mul_start = accept && (op == OP_MUL);

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );

    // Multiply flags: carry flags a nonzero high half, overflow is never set.
    always_comb begin
        mul_flags        = '0;
        mul_flags[FLG_C] = (mul_product[2*WIDTH-1:WIDTH] != '0);
        mul_flags[FLG_N] = mul_product[WIDTH-1];
        mul_flags[FLG_Z] = (mul_product[WIDTH-1:0] == '0);
    end

    assign busy = (state == ST_MUL);
`else
    assign busy = 1'b0;
`endif

    // Control FSM and output register; a consume clears out_valid unless a new result lands the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
`ifdef ALU_MUL_EN
                        if (op == OP_MUL) begin
                            state <= ST_MUL;
                        end else
`endif
                        begin
                            result    <= alu_res;
                            flags     <= alu_flags;
                            out_valid <= 1'b1;
                        end
                    end
                end
`ifdef ALU_MUL_EN
                ST_MUL: begin
                    if (mul_done && out_free) begin
                        result    <= mul_product[WIDTH-1:0];
                        flags     <= mul_flags;
                        out_valid <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the team's 8-bit combinational ALU.
- Accepts operand pairs over a valid/ready handshake and returns the result plus status flags from an output register.
- Optional iterative multiplier adds a real multi-cycle path.
- Sits between an operand-issue stage and a writeback consumer. Either side may stall.

Parameters:
- WIDTH, 8, operand and result width in bits (>=4, power of 2)
- SHW, $clog2(WIDTH), shift-amount width (derived; not overridden)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand/op presented
- in_ready  output  1  block can accept operands this cycle
- op  input  3  operation code
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out_valid  output  1  result register holds an unconsumed result
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  registered result
- flags  output  4  {carry, overflow, negative, zero}, registered with result
- busy  output  1  multi-cycle op in progress

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous and active-low.
- Reset values: out_valid=0, result=0, flags=0, busy=0, FSM=IDLE. in_ready=1 once rst_n deasserts.
- Reset mid-multiply: the operation is abandoned and no result is produced.
- Op codes:
  - 000 ADD: a+b
  - 001 SUB: a-b
  - 010 AND
  - 011 NOT: ~a
  - 100 OR
  - 101 XOR
  - 110 MUL (optional feature)
  - 111 SHR: a >> b[SHW-1:0], logical
- Width rules: all arithmetic is mod 2^WIDTH. Result is truncated to WIDTH bits.
- carry:
  - ADD: carry-out of the WIDTH-bit sum.
  - SUB: borrow, i.e. 1 iff a<b unsigned.
  - All other ops: 0.
- overflow: two's-complement signed overflow for ADD/SUB; 0 otherwise.
- negative = result[WIDTH-1]; zero = (result==0).
- Handshake:
  - Accept occurs when in_valid && in_ready.
  - Result consumed when out_valid && out_ready.
  - Inputs are sampled only on accept. Changing them while not accepted has no effect.
- in_ready = (state==IDLE) && (!out_valid || out_ready). This allows back-to-back throughput of 1 op/cycle when the consumer is always ready.
- Single-cycle ops: result, flags and out_valid=1 are registered on the accept edge (latency 1).
- Simultaneous consume and accept: the new result replaces the old one; out_valid stays 1.
- Consume without a new accept: out_valid clears next edge. result/flags hold their last value.
- Stall: while out_valid && !out_ready, result/flags/out_valid are held stable and in_ready=0.
- FSM: IDLE and MUL (MUL exists only with the feature).

Optional Feature:
- Macro: ALU_MUL_EN.
- Defined:
  - On accept of op=110, the FSM goes IDLE->MUL and busy=1.
  - Shift-add, one bit of b per cycle, for WIDTH cycles.
  - On the last iteration: result = low WIDTH bits of a*b (unsigned), and out_valid=1 (latency WIDTH cycles).
  - carry = 1 iff the high half of the product is nonzero; overflow=0.
  - FSM returns to IDLE and busy=0.
  - in_ready=0 throughout MUL.
  - The MUL->result transition waits only for the output register to be free (!out_valid || out_ready).
- Undefined:
  - op=110 yields result=0, flags zero=1, others 0, with latency 1.
  - busy is tied 0 and the MUL state and multiplier datapath are absent.

Decomposition:
- Package alu_pkg: op-code localparams (OP_ADD..OP_SHR), flag bit indices (FLG_Z=0, FLG_N=1, FLG_V=2, FLG_C=3), and the FSM state encoding.
- One sub-module, alu_mul_iter:
  - Ports: clk, rst_n, start, a, b, done, product[2*WIDTH-1:0].
  - Instantiated only under ALU_MUL_EN.
- The combinational op/flag datapath stays in alu_seq.

Test Plan:
1. Reset, WIDTH=8: assert rst_n=0 mid-stream -> out_valid=0, result=0x00, flags=0 immediately (async); in_ready=1 after release.
2. ADD a=0xFF b=0x01 -> next cycle result=0x00, flags C=1 Z=1 V=0 N=0. ADD 0x7F+0x01 -> 0x80, V=1 N=1 C=0.
3. SUB a=0x10 b=0x20 -> 0xF0, C=1 N=1. Then NOT 0x0F -> 0xF0, C=0. Then SHR 0x80 by 3 -> 0x10.
4. Back-to-back: 4 ADDs on consecutive cycles with out_ready=1 -> 4 results on consecutive cycles. Hold out_ready=0 for 3 cycles -> in_ready=0 and result stable throughout; release -> next op accepted the same cycle.
5. ALU_MUL_EN: MUL 0x0C*0x0B -> busy=1 for 8 cycles, then result=0x84, C=0. MUL 0x10*0x10 -> 0x00, C=1, Z=1. Without the macro, MUL -> 0x00, Z=1, latency 1.
6. Reset asserted during cycle 4 of MUL -> busy=0, out_valid=0, FSM=IDLE. A subsequent ADD 2+3 returns 0x05.
